// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and constants for the ALU-stage sequencer: FSM state encoding
// and the opcode set understood by the downstream multi-cycle ALU stage.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LA   = 3'd1,
        S_WB   = 3'd2,
        S_LB   = 3'd3,
        S_EXEC = 3'd4,
        S_FIRE = 3'd5,
        S_CAP  = 3'd6,
        S_RESP = 3'd7
    } state_e;

    localparam int OPW_DEF = 4;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_PASSA = 4'd7;
    localparam logic [3:0] OP_PASSB = 4'd8;

    // Opcodes above this value are rejected without touching the ALU.
    localparam int OP_MAX_DEF = 8;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Bundle of the sequencer's operand channel, ALU-stage drive/return and
// response channel; "slave" is the sequencer's view, "master" its environment's.
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int CNT_W = 16
) ();
    // valid/ready: a word moves on a rising clk edge where valid and ready are
    // both high; valid without ready is simply ignored, payload need not be held.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [OPW-1:0]   in_op;

    logic             ld_a;
    logic             ld_b;
    logic             ld_f;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_f;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [OPW-1:0]   res_op;
    logic             res_err;

    logic             busy;
    logic [CNT_W-1:0] done_cnt;

    modport slave (
        input  in_valid, in_data, in_op, alu_f, res_ready,
        output in_ready, ld_a, ld_b, ld_f, alu_a, alu_b, alu_op,
               res_valid, res_data, res_op, res_err, busy, done_cnt
    );

    modport master (
        output in_valid, in_data, in_op, alu_f, res_ready,
        input  in_ready, ld_a, ld_b, ld_f, alu_a, alu_b, alu_op,
               res_valid, res_data, res_op, res_err, busy, done_cnt
    );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Moore sequencer feeding the multi-cycle ALU stage: loads A then B, waits the
// execute time, fires F, captures the result and holds it for the consumer.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int OPW       = OPW_DEF,
    parameter int EXEC_WAIT = 1,
    parameter int OP_MAX    = OP_MAX_DEF,
    parameter int CNT_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    alu_seq_ctrl_if.slave  bus,
    output logic [2:0]     o_state
);

    localparam logic [2:0] ST_IDLE = S_IDLE;
    localparam logic [2:0] ST_LA   = S_LA;
    localparam logic [2:0] ST_WB   = S_WB;
    localparam logic [2:0] ST_LB   = S_LB;
    localparam logic [2:0] ST_EXEC = S_EXEC;
    localparam logic [2:0] ST_FIRE = S_FIRE;
    localparam logic [2:0] ST_CAP  = S_CAP;
    localparam logic [2:0] ST_RESP = S_RESP;

    localparam int              WAIT_W    = (EXEC_WAIT < 1) ? 1 : $clog2(EXEC_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(EXEC_WAIT);
    localparam logic [OPW-1:0]  OP_MAX_V  = OPW'(OP_MAX);

    logic [2:0]        r_state;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_alu_b;
    logic [OPW-1:0]    r_alu_op;
    logic [WIDTH-1:0]  r_res_data;
    logic [OPW-1:0]    r_res_op;
    logic              r_res_err;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_done_cnt;

    logic w_in_ready;
    logic w_in_fire;
    logic w_res_valid;
    logic w_op_illegal;

    assign w_in_ready   = (r_state == ST_IDLE) || (r_state == ST_WB);
    assign w_in_fire    = bus.in_valid && w_in_ready;
    assign w_res_valid  = (r_state == ST_RESP);
    assign w_op_illegal = (r_alu_op > OP_MAX_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_res_data <= '0;
            r_res_op   <= '0;
            r_res_err  <= 1'b0;
            r_wait     <= '0;
            r_done_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_alu_a <= bus.in_data;
                        r_state <= ST_LA;
                    end
                end
                ST_LA: r_state <= ST_WB;
                ST_WB: begin
                    if (w_in_fire) begin
                        r_alu_b  <= bus.in_data;
                        r_alu_op <= bus.in_op;
                        r_state  <= ST_LB;
                    end
                end
                ST_LB: begin
                    // An illegal opcode skips FIRE entirely so the ALU F register is untouched.
                    if (w_op_illegal) begin
                        r_res_err  <= 1'b1;
                        r_res_data <= '0;
                        r_res_op   <= r_alu_op;
                        r_state    <= ST_RESP;
                    end else begin
                        r_wait    <= WAIT_INIT;
                        r_res_err <= 1'b0;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_wait == '0) begin
                        r_state <= ST_FIRE;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                ST_FIRE: r_state <= ST_CAP;
                ST_CAP: begin
                    r_res_data <= bus.alu_f;
                    r_res_op   <= r_alu_op;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        r_done_cnt <= r_done_cnt + CNT_W'(1);
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.ld_a      = (r_state == ST_LA);
    assign bus.ld_b      = (r_state == ST_LB);
    assign bus.ld_f      = (r_state == ST_FIRE);
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_op    = r_alu_op;
    assign bus.res_valid = w_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_op    = r_res_op;
    assign bus.res_err   = r_res_err;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done_cnt  = r_done_cnt;
    assign o_state       = r_state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a default instance for functional checks plus
// EXEC_WAIT=0 (narrow counter) and EXEC_WAIT=3 instances for timing and wrap.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared stimulus ----------------
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic [3:0]   in_op     = '0;
    logic         res_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [3:0]   exp_op_q[$];
    logic         exp_err_q[$];
    bit           sb_en = 1'b1;
    logic [15:0]  exp_done = '0;

    int n_lda = 0;
    int n_ldb = 0;
    int n_ldf = 0;

    alu_seq_ctrl_if #(.WIDTH(W), .OPW(4), .CNT_W(16)) m_if ();
    alu_seq_ctrl_if #(.WIDTH(W), .OPW(4), .CNT_W(3))  w0_if ();
    alu_seq_ctrl_if #(.WIDTH(W), .OPW(4), .CNT_W(16)) w3_if ();

    logic [2:0]   st_m, st_0, st_3;
    logic [W-1:0] f_m = '0, f_0 = '0, f_3 = '0;

    // Reference behaviour of the downstream ALU stage's F register.
    function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [3:0] op);
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_SHL:   return a << b[4:0];
            OP_SHR:   return a >> b[4:0];
            OP_PASSA: return a;
            OP_PASSB: return b;
            default:  return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (m_if.ld_f)  f_m <= alu_model(m_if.alu_a, m_if.alu_b, m_if.alu_op);
        if (w0_if.ld_f) f_0 <= alu_model(w0_if.alu_a, w0_if.alu_b, w0_if.alu_op);
        if (w3_if.ld_f) f_3 <= alu_model(w3_if.alu_a, w3_if.alu_b, w3_if.alu_op);
    end

    assign m_if.in_valid  = in_valid;
    assign m_if.in_data   = in_data;
    assign m_if.in_op     = in_op;
    assign m_if.res_ready = res_ready;
    assign m_if.alu_f     = f_m;
    assign w0_if.in_valid  = in_valid;
    assign w0_if.in_data   = in_data;
    assign w0_if.in_op     = in_op;
    assign w0_if.res_ready = res_ready;
    assign w0_if.alu_f     = f_0;
    assign w3_if.in_valid  = in_valid;
    assign w3_if.in_data   = in_data;
    assign w3_if.in_op     = in_op;
    assign w3_if.res_ready = res_ready;
    assign w3_if.alu_f     = f_3;

    alu_seq_ctrl #(.WIDTH(W), .OPW(4), .EXEC_WAIT(1), .OP_MAX(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(m_if), .o_state(st_m)
    );
    alu_seq_ctrl #(.WIDTH(W), .OPW(4), .EXEC_WAIT(0), .OP_MAX(8), .CNT_W(3)) u_dut_w0 (
        .clk(clk), .rst(rst), .bus(w0_if), .o_state(st_0)
    );
    alu_seq_ctrl #(.WIDTH(W), .OPW(4), .EXEC_WAIT(3), .OP_MAX(8), .CNT_W(16)) u_dut_w3 (
        .clk(clk), .rst(rst), .bus(w3_if), .o_state(st_3)
    );

    always @(posedge clk) begin
        if (m_if.ld_a) n_lda++;
        if (m_if.ld_b) n_ldb++;
        if (m_if.ld_f) n_ldf++;
    end

    // ---------------- scoreboard ----------------
    always begin
        @(negedge clk);
        #1;
        if (sb_en && !rst && m_if.res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow got data=%h op=%0d err=%0b want no response",
                         m_if.res_data, m_if.res_op, m_if.res_err);
            end else begin
                logic [W-1:0] e;
                logic [3:0]   eo;
                logic         ee;
                e  = exp_q.pop_front();
                eo = exp_op_q.pop_front();
                ee = exp_err_q.pop_front();
                if (m_if.res_data !== e || m_if.res_op !== eo || m_if.res_err !== ee) begin
                    errors++;
                    $display("FAIL sb_result got data=%h op=%0d err=%0b want data=%h op=%0d err=%0b",
                             m_if.res_data, m_if.res_op, m_if.res_err, e, eo, ee);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        exp_q.push_back((op > 4'd8) ? '0 : alu_model(a, b, op));
        exp_op_q.push_back(op);
        exp_err_q.push_back(op > 4'd8);
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_op_q.delete();
        exp_err_q.delete();
        exp_done = '0;
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic [3:0] op);
        int n = 0;
        while (!m_if.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_timeout got in_ready=%0b want 1", m_if.in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_op    = 4'($urandom);
    endtask

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                           input int exp_ldf, input int exp_rv);
        int k_ldb = -1;
        int k_ldf = -1;
        int k_rv  = -1;
        n_lda = 0; n_ldb = 0; n_ldf = 0;
        res_ready = 1'b1;
        send_word(a, 4'($urandom));
        checks++;
        if (m_if.ld_a !== 1'b1) begin
            errors++;
            $display("FAIL lda_latency got ld_a=%0b want 1", m_if.ld_a);
        end
        push_exp(a, b, op);
        send_word(b, op);
        for (int k = 1; k <= 30; k++) begin
            if (m_if.ld_b && k_ldb < 0) k_ldb = k;
            if (m_if.ld_f && k_ldf < 0) k_ldf = k;
            if (m_if.res_valid) begin
                k_rv = k;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        exp_done++;
        checks++;
        if (k_ldb !== 1) begin errors++; $display("FAIL ldb_latency got %0d want 1", k_ldb); end
        checks++;
        if (k_ldf !== exp_ldf) begin errors++; $display("FAIL ldf_latency got %0d want %0d", k_ldf, exp_ldf); end
        checks++;
        if (k_rv !== exp_rv) begin errors++; $display("FAIL res_valid_latency got %0d want %0d", k_rv, exp_rv); end
        checks++;
        if (n_lda != 1 || n_ldb != 1 || n_ldf != ((exp_ldf < 0) ? 0 : 1)) begin
            errors++;
            $display("FAIL strobe_count got a=%0d b=%0d f=%0d want 1 1 %0d",
                     n_lda, n_ldb, n_ldf, (exp_ldf < 0) ? 0 : 1);
        end
        checks++;
        if (m_if.done_cnt !== exp_done) begin
            errors++;
            $display("FAIL done_cnt got %0d want %0d", m_if.done_cnt, exp_done);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({m_if.in_ready, m_if.busy, m_if.ld_a, m_if.ld_b, m_if.ld_f, m_if.res_valid} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/busy/a/b/f/rv=%b want 100000",
                     {m_if.in_ready, m_if.busy, m_if.ld_a, m_if.ld_b, m_if.ld_f, m_if.res_valid});
        end
        checks++;
        if (st_m !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", st_m, S_IDLE); end
        checks++;
        if (m_if.alu_a !== '0 || m_if.alu_b !== '0 || m_if.alu_op !== '0) begin
            errors++;
            $display("FAIL reset_alu got a=%h b=%h op=%0d want 0 0 0", m_if.alu_a, m_if.alu_b, m_if.alu_op);
        end
        checks++;
        if (m_if.res_data !== '0 || m_if.res_op !== '0 || m_if.res_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_res got data=%h op=%0d err=%0b want 0 0 0",
                     m_if.res_data, m_if.res_op, m_if.res_err);
        end
        checks++;
        if (m_if.done_cnt !== '0) begin errors++; $display("FAIL reset_done_cnt got %0d want 0", m_if.done_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_txn(32'h0000_0005, 32'h0000_0003, OP_ADD, 4, 6);
        run_txn($urandom, $urandom, OP_XOR, 4, 6);
        run_txn($urandom, $urandom, OP_SHR, 4, 6);
    endtask

    task automatic test_illegal();
        run_txn($urandom, $urandom, 4'hF, -1, 2);
        run_txn($urandom, $urandom, 4'd9, -1, 2);
        run_txn($urandom, $urandom, OP_PASSB, 4, 6);
    endtask

    task automatic test_stall();
        logic [W-1:0] a = $urandom;
        logic [W-1:0] b = $urandom;
        int n = 0;
        n_ldf = 0;
        res_ready = 1'b0;
        send_word(a, 4'($urandom));
        push_exp(a, b, OP_SUB);
        send_word(b, OP_SUB);
        while (!m_if.res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({m_if.res_valid, m_if.in_ready, m_if.busy} !== 3'b101) begin
                errors++;
                $display("FAIL stall_ctrl cycle %0d got rv/rdy/busy=%b want 101", i,
                         {m_if.res_valid, m_if.in_ready, m_if.busy});
            end
            checks++;
            if (exp_q.size() == 0 || m_if.res_data !== exp_q[0]) begin
                errors++;
                $display("FAIL stall_data cycle %0d got %h want %h", i, m_if.res_data,
                         alu_model(a, b, OP_SUB));
            end
            checks++;
            if (m_if.done_cnt !== exp_done) begin
                errors++;
                $display("FAIL stall_done_cnt cycle %0d got %0d want %0d", i, m_if.done_cnt, exp_done);
            end
            in_valid = (i % 2 == 1);
            in_data  = $urandom;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        exp_done++;
        checks++;
        if (m_if.done_cnt !== exp_done || n_ldf != 1 || m_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got done=%0d ldf=%0d busy=%0b want %0d 1 0",
                     m_if.done_cnt, n_ldf, m_if.busy, exp_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[6];
        logic [3:0]   ops[3];
        int           lda_t[$];
        int           idx = 0;
        int           d1, d2;
        for (int i = 0; i < 3; i++) begin
            words[2*i]   = $urandom;
            words[2*i+1] = $urandom;
            ops[i]       = 4'($urandom_range(0, 8));
        end
        res_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (m_if.ld_a) lda_t.push_back(cyc);
            if (m_if.in_ready) begin
                if (idx == 6) break;
                in_valid = 1'b1;
                in_data  = words[idx];
                if (idx % 2 == 1) begin
                    in_op = ops[idx/2];
                    push_exp(words[idx-1], words[idx], ops[idx/2]);
                end else begin
                    in_op = 4'($urandom);
                end
                idx++;
            end else begin
                in_data = $urandom;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        exp_done += 16'd3;
        d1 = (lda_t.size() >= 2) ? lda_t[1] - lda_t[0] : -1;
        d2 = (lda_t.size() >= 3) ? lda_t[2] - lda_t[1] : -1;
        checks++;
        if (d1 != 9 || d2 != 9) begin
            errors++;
            $display("FAIL b2b_period got %0d %0d want 9 9", d1, d2);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d pending want 0", exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (m_if.done_cnt !== exp_done) begin
            errors++;
            $display("FAIL b2b_done_cnt got %0d want %0d", m_if.done_cnt, exp_done);
        end
    endtask

    task automatic test_reset_mid();
        n_ldf = 0;
        res_ready = 1'b1;
        send_word($urandom, 4'($urandom));
        send_word($urandom, OP_ADD);
        @(negedge clk);
        checks++;
        if (st_m !== S_EXEC) begin errors++; $display("FAIL mid_state got %0d want %0d", st_m, S_EXEC); end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_if.in_ready, m_if.busy, m_if.ld_a, m_if.ld_b, m_if.ld_f, m_if.res_valid} !== 6'b100000) begin
            errors++;
            $display("FAIL mid_reset_ctrl got rdy/busy/a/b/f/rv=%b want 100000",
                     {m_if.in_ready, m_if.busy, m_if.ld_a, m_if.ld_b, m_if.ld_f, m_if.res_valid});
        end
        checks++;
        if (m_if.done_cnt !== '0 || m_if.alu_b !== '0) begin
            errors++;
            $display("FAIL mid_reset_regs got done=%0d alu_b=%h want 0 0", m_if.done_cnt, m_if.alu_b);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (n_ldf != 0 || m_if.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_fire got ldf=%0d rv=%0b want 0 0", n_ldf, m_if.res_valid);
        end
        exp_done = '0;
        run_txn($urandom, $urandom, OP_AND, 4, 6);
    endtask

    task automatic test_exec_wait();
        int bm = -1, fm = -1, b0 = -1, f0 = -1, b3 = -1, f3 = -1;
        reset_all();
        res_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'd7; in_op = 4'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        push_exp(32'd7, 32'd2, OP_SUB);
        in_valid = 1'b1; in_data = 32'd2; in_op = OP_SUB;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (m_if.ld_b  && bm < 0) bm = k;
            if (m_if.ld_f  && fm < 0) fm = k;
            if (w0_if.ld_b && b0 < 0) b0 = k;
            if (w0_if.ld_f && f0 < 0) f0 = k;
            if (w3_if.ld_b && b3 < 0) b3 = k;
            if (w3_if.ld_f && f3 < 0) f3 = k;
            @(negedge clk);
        end
        exp_done++;
        checks++;
        if (fm - bm != 3) begin errors++; $display("FAIL wait1_distance got %0d want 3", fm - bm); end
        checks++;
        if (f0 - b0 != 2) begin errors++; $display("FAIL wait0_distance got %0d want 2", f0 - b0); end
        checks++;
        if (f3 - b3 != 5) begin errors++; $display("FAIL wait3_distance got %0d want 5", f3 - b3); end
        checks++;
        if (m_if.done_cnt !== exp_done || w0_if.done_cnt !== 3'd1 || w3_if.done_cnt !== 16'd1) begin
            errors++;
            $display("FAIL wait_done_cnt got %0d %0d %0d want %0d 1 1",
                     m_if.done_cnt, w0_if.done_cnt, w3_if.done_cnt, exp_done);
        end
    endtask

    task automatic test_wrap();
        int hs = 0;
        bit seen7 = 1'b0;
        reset_all();
        sb_en = 1'b0;
        res_ready = 1'b1;
        in_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (hs == 7 && !seen7) begin
                seen7 = 1'b1;
                checks++;
                if (w0_if.done_cnt !== 3'd7) begin
                    errors++;
                    $display("FAIL wrap_full got %0d want 7", w0_if.done_cnt);
                end
            end
            if (hs == 8) break;
            if (w0_if.res_valid && res_ready) hs++;
            in_data = $urandom;
            in_op   = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (hs != 8 || w0_if.done_cnt !== 3'd0) begin
            errors++;
            $display("FAIL wrap_zero got hs=%0d done=%0d want 8 0", hs, w0_if.done_cnt);
        end
        reset_all();
        sb_en = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_exec_wait();
        test_wrap();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Single-clock sequencer that sits directly upstream of the multi-cycle ALU stage. It drives the ALU stage's A, B and F register load strobes, operand buses and opcode. It accepts two operand words over a valid/ready input channel and waits a programmable execute time. It then captures the ALU stage's registered result and presents it on a valid/ready response channel.

## Interface
- WIDTH, 32, operand/result width
- OPW, 4, opcode width
- EXEC_WAIT, 1, extra cycles between B load and F load (0 allowed)
- OP_MAX, 8, highest legal opcode; opcodes above are rejected
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand word valid
- in_ready  out  1  sequencer can accept operand word
- in_data  in  WIDTH  operand word (first = A, second = B)
- in_op  in  OPW  opcode, sampled only with the B word
- ld_a  out  1  one-cycle load strobe for ALU A register
- ld_b  out  1  one-cycle load strobe for ALU B register
- ld_f  out  1  one-cycle load strobe for ALU F/FR registers
- alu_a  out  WIDTH  registered A operand
- alu_b  out  WIDTH  registered B operand
- alu_op  out  OPW  registered opcode
- alu_f  in  WIDTH  registered F output of ALU stage
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  captured result (0 on error)
- res_op  out  OPW  opcode of this result
- res_err  out  1  opcode was illegal, no execution performed
- busy  out  1  state != IDLE
- done_cnt  out  CNT_W  count of completed response handshakes

## Operation
- Moore FSM with states IDLE, LA, WB, LB, EXEC, FIRE, CAP, RESP.
- All strobes are decoded from state:
  - ld_a=1 only in LA.
  - ld_b=1 only in LB.
  - ld_f=1 only in FIRE.
  - res_valid=1 only in RESP.
  - in_ready=1 only in IDLE and WB.
- IDLE: on in_valid&in_ready, alu_a<=in_data, go LA.
- LA: go WB (one cycle).
- WB: on handshake, alu_b<=in_data, alu_op<=in_op, go LB.
- LB (one cycle):
  - if alu_op>OP_MAX: res_err<=1, res_data<=0, res_op<=alu_op, go RESP. No FIRE, so ld_f is never asserted.
  - else: wait counter<=EXEC_WAIT, res_err<=0, go EXEC.
- EXEC: if counter==0 go FIRE, else counter decrements. EXEC lasts EXEC_WAIT+1 cycles.
- FIRE: go CAP. The ALU stage's F register updates at the end of FIRE.
- CAP: res_data<=alu_f, res_op<=alu_op, go RESP.
- RESP: hold res_* stable while res_valid=1 and res_ready=0. On handshake, done_cnt increments (wraps 2^CNT_W−1 → 0) and the FSM goes to IDLE.
- No overlap: a new A word is never accepted before the response handshake completes.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE
  - alu_a=alu_b=0, alu_op=0
  - res_data=0, res_op=0, res_err=0
  - done_cnt=0, counter=0
  - all strobes=0, in_ready=1, res_valid=0, busy=0
- Reset mid-operation aborts the current operation with no further strobes. A pending result is discarded and not counted.
- Latency, with the B handshake on the edge ending cycle t:
  - ld_b in t+1
  - ld_f in t+3+EXEC_WAIT
  - first res_valid in t+5+EXEC_WAIT (t+6 at default)
- Illegal opcode: res_valid in t+2, res_err=1.
- A handshake to ld_a: 1 cycle.
- Fastest full transaction, with back-to-back valids and res_ready held high: 8+EXEC_WAIT cycles.
- in_valid while in_ready=0 is ignored; in_data need not be held.

## Structure
- Package alu_seq_pkg holds:
  - state enum (8 states)
  - opcode localparams for the ALU stage's op set, including OP_MAX default
- No sub-module; the wait counter and done counter are inline.

## Test plan
- Reset then A=0x0000_0005, B=0x0000_0003, op=0 (ADD); the ALU model returns 0x8 after ld_f -> exactly one pulse each of ld_a/ld_b/ld_f, res_data=0x8, res_op=0, res_err=0, res_valid at t+6, done_cnt=1.
- op=4'hF with any operands -> ld_f never pulses, res_err=1, res_data=0, res_valid at t+2, done_cnt increments.
- Hold res_ready=0 for 10 cycles in RESP -> res_valid and res_data stay stable, in_valid pulses are ignored (in_ready=0), done_cnt unchanged until release.
- Run with EXEC_WAIT=0 and EXEC_WAIT=3 -> the ld_b→ld_f distance is 2 and 5 cycles respectively.
- Assert rst during EXEC -> outputs return to reset values immediately, no ld_f, done_cnt=0. The next transaction completes normally.
- Preload done_cnt to 0xFFFF via 65535 transactions (or a forced state) -> the next handshake wraps it to 0x0000.
